pipe_seq_ctrl: RTL and testbench
================================

# pipe_seq_ctrl

Sequencing and hazard controller for the 4-stage 8-bit pipeline (IF, ID, EX, WB). It owns the fetch PC and the start/done handshake, and tracks valid/destination state per stage. It detects read-after-write hazards and stalls ID, inserting EX bubbles, because the datapath has no forwarding. It drains the pipeline on HALT and then signals completion.

## Interface
- `IMEM_DEPTH`, 16: instruction memory words; PC wraps modulo this.
- `RAW`, 2: register address width (4 architectural registers).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin execution at PC 0; sampled only in IDLE.
- `instr` in 8: instruction word at `pc` (combinational imem read).
- `pc` out log2(IMEM_DEPTH): fetch address.
- `if_en` out 1: load IF/ID register with `instr` this edge.
- `id_ex_en` out 1: move ID into EX; when 0 during RUN/DRAIN, EX receives a bubble.
- `ex_valid` out 1: EX holds a real instruction.
- `wb_we` out 1: register-file write enable in WB.
- `wb_rd` out RAW: register-file write address in WB.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle completion pulse.
- `stall_cnt` out 8: saturating count of stall cycles since the last `start`.

## Operation
- Instruction format: op[7:6], rd[5:4], rs_a[3:2], rs_b[1:0].
  - 00 ADD: rd = rs_a + rs_b.
  - 01 SUB: rd = rs_a − rs_b.
  - 10 LOAD: rd = rs_a; reads rs_a only.
  - 11 HALT: no sources, no write.
- Per-stage state:
  - ID: valid and the full instruction.
  - EX: valid and rd.
  - WB: valid and rd.
- States: IDLE → RUN on `start` → DRAIN when HALT is valid in ID → IDLE when EX and WB are both invalid.
- Hazard condition: a valid non-HALT instruction in ID has a read source equal to the rd of a valid EX or a valid WB instruction.
  - The WB stage counts as a hazard because the write lands at the end of the WB cycle; there is no write-through.
- Stall behaviour:
  - `if_en` = 0, `pc` held, ID held, `id_ex_en` = 0 (EX bubble), `stall_cnt` +1 (saturates at 255).
- No stall in RUN:
  - `if_en` = 1, `pc` increments, wrapping from IMEM_DEPTH−1 to 0.
  - `id_ex_en` = ID valid.
- HALT in ID:
  - HALT never enters EX.
  - `if_en` = 0 from that cycle on, and ID is invalidated.
  - Older instructions in EX and WB complete normally.
- `start` while `busy` is ignored.
- `start` in IDLE clears `stall_cnt` and sets `pc` to 0.

## Timing
- Reset values: `pc` = 0, all stage valids = 0, state IDLE, `if_en` = `id_ex_en` = `ex_valid` = `wb_we` = 0, `wb_rd` = 0, `busy` = 0, `done` = 0, `stall_cnt` = 0.
- Reset asserted mid-run aborts immediately. No `done` pulse and no further writes occur.
- `start` sampled at edge E0 → `busy` = 1 and `if_en` = 1 with `pc` = 0 in the next cycle.
  - Instruction k (no stalls) is in ID after edge E(k+1), in EX after E(k+2), and in WB after E(k+3).
- Latency: 3 edges from fetch to WB, plus 1 per stall cycle. A dependency gives at most 2 stall cycles.
  - Adjacent dependent pair: 2 stalls.
  - Distance 2: 1 stall.
  - Distance ≥3: 0 stalls.
- `done` is high for exactly the one cycle following the edge at which the last valid instruction leaves WB. `busy` falls at that same edge.
- All outputs are registered, except these combinational outputs: `if_en`, `id_ex_en`, and the hazard term.

## Structure
- Shared package `pipe_pkg` holds:
  - opcode constants (OP_ADD, OP_SUB, OP_LOAD, OP_HALT);
  - field bit positions;
  - the state enum (IDLE, RUN, DRAIN);
  - an instruction struct.
  - The datapath imports the same package.
- One sub-module, `pipe_scoreboard`: holds EX/WB valid+rd and computes the hazard flag for the ID sources. The FSM, PC and counter stay in the top module.

## Test plan
- Program [ADD r1,r0,r0; ADD r2,r0,r0; HALT], `start` at E0:
  - `wb_we` with `wb_rd` = 1 after E3, `wb_rd` = 2 after E4;
  - `done` pulse after E5;
  - `stall_cnt` = 0.
- [ADD r1,r0,r0; ADD r2,r1,r1; HALT]:
  - exactly 2 stall cycles, with `pc` held at 2;
  - `wb_rd` = 2 after E6;
  - `stall_cnt` = 2.
- [ADD r1,r0,r0; ADD r3,r0,r0; LOAD r2,r1; HALT]:
  - exactly 1 stall cycle;
  - `stall_cnt` = 1.
  - LOAD's rs_b field = 1 still causes no extra stall.
- `start` pulsed while `busy`: no PC reset and no count clear. A second `start` after `done` reruns from `pc` 0 with `stall_cnt` cleared.
- `reset_n` low during a stall:
  - all outputs return to reset values immediately;
  - no `done` pulse and no `wb_we`.
- 16 independent ADDs with no HALT: `pc` wraps 15 → 0 and fetch continues uninterrupted.

Source files
------------

// File: rtl/pipe_seq_ctrl_pkg.sv
// pipe_pkg: definitions shared by the pipeline sequencer and the datapath.
//   op_e     - 2-bit opcode (ADD, SUB, LOAD, HALT)
//   state_e  - sequencer state (IDLE, RUN, DRAIN)
//   instr_t  - decoded instruction: op[7:6], rd[5:4], rs_a[3:2], rs_b[1:0]
//   decode() - raw word to instr_t; reads_a()/reads_b() - source usage per op
package pipe_pkg;

  localparam int unsigned REG_AW  = 2;
  localparam int unsigned OP_POS  = 6;
  localparam int unsigned RD_POS  = 4;
  localparam int unsigned RSA_POS = 2;
  localparam int unsigned RSB_POS = 0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs_a;
    logic [REG_AW-1:0] rs_b;
  } instr_t;

  function automatic instr_t decode(input logic [7:0] w);
    instr_t d;
    d.op   = op_e'(w[OP_POS +: 2]);
    d.rd   = w[RD_POS +: REG_AW];
    d.rs_a = w[RSA_POS +: REG_AW];
    d.rs_b = w[RSB_POS +: REG_AW];
    return d;
  endfunction

  function automatic logic reads_a(input op_e op);
    return op != OP_HALT;
  endfunction

  // LOAD carries an rs_b field but never reads it
  function automatic logic reads_b(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// pipe_seq_ctrl_if: sequencer <-> datapath/imem signals.
//   master (sequencer): in start, instr; out pc, if_en, id_ex_en, ex_valid,
//                       wb_we, wb_rd, busy, done, stall_cnt
//   slave  (datapath) : the mirror image
interface pipe_seq_ctrl_if #(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned RAW        = 2
);
  localparam int unsigned PCW = $clog2(IMEM_DEPTH);

  logic            start;
  logic [7:0]      instr;
  logic [PCW-1:0]  pc;
  logic            if_en;
  logic            id_ex_en;
  logic            ex_valid;
  logic            wb_we;
  logic [RAW-1:0]  wb_rd;
  logic            busy;
  logic            done;
  logic [7:0]      stall_cnt;

  modport master (
    input  start, instr,
    output pc, if_en, id_ex_en, ex_valid, wb_we, wb_rd, busy, done, stall_cnt
  );

  modport slave (
    output start, instr,
    input  pc, if_en, id_ex_en, ex_valid, wb_we, wb_rd, busy, done, stall_cnt
  );
endinterface

// File: rtl/pipe_seq_ctrl_scoreboard.sv
// pipe_scoreboard: EX/WB valid+rd tracking and RAW hazard detection.
//   clk, reset_n      - clock, async active-low reset
//   id_valid/id_instr - instruction currently in ID
//   id_ex_en          - ID advances into EX this edge (else EX gets a bubble)
//   ex_valid          - EX holds a real instruction
//   wb_valid/wb_rd    - WB holds a real instruction and its destination
//   hazard            - ID source matches a valid EX or WB destination
import pipe_pkg::*;

module pipe_scoreboard (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  instr_t            id_instr,
  input  logic              id_ex_en,
  output logic              ex_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              hazard
);

  logic [REG_AW-1:0] ex_rd;
  logic              a_hit;
  logic              b_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
    end else begin
      ex_valid <= id_ex_en;
      if (id_ex_en) ex_rd <= id_instr.rd;
      wb_valid <= ex_valid;
      if (ex_valid) wb_rd <= ex_rd;
    end
  end

  // WB is included: the register file write only lands at the end of WB
  always_comb begin
    a_hit  = (ex_valid && (ex_rd == id_instr.rs_a)) ||
             (wb_valid && (wb_rd == id_instr.rs_a));
    b_hit  = (ex_valid && (ex_rd == id_instr.rs_b)) ||
             (wb_valid && (wb_rd == id_instr.rs_b));
    hazard = id_valid && ((reads_a(id_instr.op) && a_hit) ||
                          (reads_b(id_instr.op) && b_hit));
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: sequencing and hazard control for the 4-stage pipeline.
//   clk, reset_n - clock, async active-low reset
//   bus (master) - start/instr in; pc, if_en, id_ex_en, ex_valid, wb_we,
//                  wb_rd, busy, done, stall_cnt out
// Owns the FSM, fetch PC, ID stage register and stall counter; EX/WB
// tracking and hazard detection live in pipe_scoreboard.
import pipe_pkg::*;

module pipe_seq_ctrl #(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned RAW        = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  pipe_seq_ctrl_if.master  bus
);

  localparam int unsigned    PCW     = $clog2(IMEM_DEPTH);
  localparam logic [PCW-1:0] PC_LAST = PCW'(IMEM_DEPTH - 1);

  state_e            state;
  logic [PCW-1:0]    pc_q;
  logic              id_valid;
  instr_t            id_instr;
  logic [7:0]        stall_q;
  logic              busy_q;
  logic              done_q;
  logic              halt_in_id;
  logic              hazard;
  logic              if_en;
  logic              id_ex_en;
  logic              ex_valid;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;

  pipe_scoreboard u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .id_valid (id_valid),
    .id_instr (id_instr),
    .id_ex_en (id_ex_en),
    .ex_valid (ex_valid),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .hazard   (hazard)
  );

  // HALT is retired in ID: it stops fetch and never moves into EX
  always_comb begin
    halt_in_id = id_valid && (id_instr.op == OP_HALT);
    if_en      = (state == RUN) && !hazard && !halt_in_id;
    id_ex_en   = (state == RUN) && id_valid && !hazard && !halt_in_id;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc_q     <= '0;
      id_valid <= 1'b0;
      id_instr <= '0;
      stall_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            pc_q     <= '0;
            stall_q  <= '0;
            id_valid <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (halt_in_id) begin
            state    <= DRAIN;
            id_valid <= 1'b0;
          end else if (hazard) begin
            if (stall_q != '1) stall_q <= stall_q + 8'd1;
          end else begin
            id_valid <= 1'b1;
            id_instr <= decode(bus.instr);
            pc_q     <= (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
          end
        end
        DRAIN: begin
          // EX only receives bubbles here, so an empty EX means the
          // instruction now in WB (if any) is the last one to leave
          if (!ex_valid) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.if_en     = if_en;
  assign bus.id_ex_en  = id_ex_en;
  assign bus.ex_valid  = ex_valid;
  assign bus.wb_we     = wb_valid;
  assign bus.wb_rd     = RAW'(wb_rd);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipe_seq_ctrl_if #(.IMEM_DEPTH(16), .RAW(2)) bus ();

  logic [7:0] imem [16];
  assign bus.instr = imem[bus.pc];

  pipe_seq_ctrl #(.IMEM_DEPTH(16), .RAW(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int         prog;
    int         step;
    logic [3:0] pc;
    logic       if_en, id_ex_en, ex_valid, wb_we;
    logic [1:0] wb_rd;
    logic       busy, done;
    logic [7:0] stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int prog, int step, int pc, bit ife, bit ide, bit exv,
                              bit we, int rd, bit bsy, bit dn, int st);
    vec_t v;
    v.prog = prog; v.step = step; v.pc = 4'(pc);
    v.if_en = ife; v.id_ex_en = ide; v.ex_valid = exv; v.wb_we = we;
    v.wb_rd = 2'(rd); v.busy = bsy; v.done = dn; v.stall = 8'(st);
    return v;
  endfunction

  // {pc, if_en, id_ex_en, ex_valid, wb_we, wb_rd, busy, done, stall_cnt};
  // wb_rd only matters while wb_we is expected high
  function automatic logic [19:0] obs(input logic rd_care);
    return {bus.pc, bus.if_en, bus.id_ex_en, bus.ex_valid, bus.wb_we,
            rd_care ? bus.wb_rd : 2'b00, bus.busy, bus.done, bus.stall_cnt};
  endfunction

  function automatic logic [19:0] pack(input vec_t v);
    return {v.pc, v.if_en, v.id_ex_en, v.ex_valid, v.wb_we,
            v.wb_we ? v.wb_rd : 2'b00, v.busy, v.done, v.stall};
  endfunction

  task automatic load(input int prog);
    for (int i = 0; i < 16; i++) imem[i] = 8'hC0;
    case (prog)
      1: begin imem[0] = 8'h10; imem[1] = 8'h20; imem[2] = 8'hC0; end
      2: begin imem[0] = 8'h10; imem[1] = 8'h25; imem[2] = 8'hC0; end
      3: begin imem[0] = 8'h10; imem[1] = 8'h30; imem[2] = 8'hA5; imem[3] = 8'hC0; end
      default: for (int i = 0; i < 16; i++) imem[i] = 8'h10;
    endcase
  endtask

  // returns at the negedge following E0 (the edge that samples start)
  task automatic start_pulse();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic run_table(input int prog);
    bit first = 1;
    load(prog);
    start_pulse();
    foreach (tbl[i]) begin
      if (tbl[i].prog == prog) begin
        if (!first) @(negedge clk);
        first = 0;
        check($sformatf("prog%0d_E%0d", prog, tbl[i].step), 32'(obs(tbl[i].wb_we)), 32'(pack(tbl[i])));
      end
    end
  endtask

  initial begin
    int done_step;
    int cnt;
    logic [1:0] wb_log[$];

    //           prog step pc if idex exv we rd busy done stall
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 2, 2, 1, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 3, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4, 3, 0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(1, 5, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(2, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(2, 2, 2, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(2, 3, 2, 0, 0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(2, 4, 2, 1, 1, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(2, 5, 3, 0, 0, 1, 0, 0, 1, 0, 2));
    tbl.push_back(mk(2, 6, 3, 0, 0, 0, 1, 2, 1, 0, 2));
    tbl.push_back(mk(2, 7, 3, 0, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(2, 8, 3, 0, 0, 0, 0, 0, 0, 0, 2));

    bus.start = 1'b0;
    reset_n   = 1'b0;
    load(1);
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(obs(1'b1)), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(obs(1'b1)), 32'h0);

    run_table(1);
    run_table(2);

    // LOAD r2,r1 with rs_b=1; a start pulse during RUN must be ignored
    load(3);
    start_pulse();
    done_step = -1;
    for (int step = 0; step <= 30; step++) begin
      if (step > 0) @(negedge clk);
      if (bus.wb_we) wb_log.push_back(bus.wb_rd);
      if (step == 4) bus.start = 1'b1;
      if (step == 5) begin
        bus.start = 1'b0;
        check("busy_start_pc", 32'(bus.pc), 32'd4);
        check("busy_start_stall", 32'(bus.stall_cnt), 32'd1);
      end
      if (bus.done) begin
        done_step = step;
        break;
      end
    end
    check("p3_done_step", 32'(done_step), 32'd7);
    check("p3_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    check("p3_wb_count", 32'(wb_log.size()), 32'd3);
    if (wb_log.size() == 3)
      check("p3_wb_order", 32'({wb_log[0], wb_log[1], wb_log[2]}), 32'({2'd1, 2'd3, 2'd2}));

    // rerun after done: pc back to 0 and counter cleared
    @(negedge clk);
    start_pulse();
    check("rerun_pc_stall_busy", 32'({bus.pc, bus.stall_cnt, bus.busy}), 32'({4'd0, 8'd0, 1'b1}));
    done_step = -1;
    for (int step = 1; step <= 30; step++) begin
      @(negedge clk);
      if (bus.done) begin
        done_step = step;
        break;
      end
    end
    check("rerun_done_step", 32'(done_step), 32'd7);
    check("rerun_stall_cnt", 32'(bus.stall_cnt), 32'd1);

    // reset asserted mid-stall with EX holding a valid instruction
    @(negedge clk);
    load(2);
    start_pulse();
    repeat (2) @(negedge clk);
    check("pre_abort_stall", 32'({bus.if_en, bus.ex_valid}), 32'({1'b0, 1'b1}));
    #2 reset_n = 1'b0;
    #1 check("abort_outputs", 32'(obs(1'b1)), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.wb_we || bus.busy) cnt++;
    end
    check("abort_no_activity", 32'(cnt), 32'd0);

    // 16 independent ADDs, no HALT: pc wraps and fetch never pauses
    load(4);
    start_pulse();
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("wrap_E%0d", k), 32'({bus.pc, bus.if_en}), 32'({4'(k % 16), 1'b1}));
    end
    check("wrap_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
